// File: rtl/fft_params_pkg.sv
// Shared FFT frame parameters, sample/beat types and the bit-reverse helper.
package fft_params_pkg;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int DATA_W = 32;

  typedef logic [DATA_W-1:0] sample_t;

  typedef enum logic {FILL, DRAIN} ctrl_state_e;

  typedef struct packed {
    logic    last;
    sample_t data;
  } beat_t;

  function automatic logic [ADDR_W-1:0] bitrev(input logic [ADDR_W-1:0] addr);
    logic [ADDR_W-1:0] r;
    for (int i = 0; i < ADDR_W; i++) r[i] = addr[ADDR_W-1-i];
    return r;
  endfunction
endpackage

// File: rtl/fft_skid_fifo2.sv
// Two-entry valid/ready buffer carrying {last, data}; exposes its occupancy so
// the read issuer can reserve space for data already in flight.
module fft_skid_fifo2
  import fft_params_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  beat_t      push_beat,
  input  logic       pop,
  output logic       valid,
  output beat_t      head,
  output logic [1:0] count
);
  beat_t      ent [2];
  logic       wp, rp;
  logic [1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp  <= 1'b0;
      rp  <= 1'b0;
      cnt <= 2'd0;
    end else begin
      if (push) wp <= ~wp;
      if (pop)  rp <= ~rp;
      cnt <= cnt + 2'(push) - 2'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) ent[wp] <= push_beat;
  end

  assign valid = (cnt != 2'd0);
  assign head  = ent[rp];
  assign count = cnt;
endmodule

// File: rtl/fft_mem_stream_ctrl.sv
// FFT sample-memory initiator: FILL writes one frame from s_*, DRAIN reads it back onto m_*.
// Define FFT_BITREV_EN to store the frame in bit-reversed address order.
module fft_mem_stream_ctrl
  import fft_params_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  input  sample_t           s_data,
  output logic              s_ready,
  output logic              m_valid,
  output sample_t           m_data,
  output logic              m_last,
  input  logic              m_ready,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output sample_t           mem_wr_data,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  sample_t           mem_rd_data,
  input  logic              mem_ready,
  output logic              frame_done
);
  ctrl_state_e       state, state_nx;
  logic [ADDR_W-1:0] wr_cnt, waddr;
  logic [ADDR_W:0]   rd_cnt;
  logic              inflight, inflight_last;
  logic              in_hs, issue, pop;
  logic              fifo_valid;
  beat_t             fifo_head;
  logic [1:0]        fifo_cnt;
  logic [2:0]        level;

`ifdef FFT_BITREV_EN
  assign waddr = bitrev(wr_cnt);
`else
  assign waddr = wr_cnt;
`endif

  fft_skid_fifo2 u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight),
    .push_beat ({inflight_last, mem_rd_data}),
    .pop       (pop),
    .valid     (fifo_valid),
    .head      (fifo_head),
    .count     (fifo_cnt)
  );

  // Buffered entries plus the read still in the memory pipe must fit in two slots.
  assign level = 3'(fifo_cnt) + 3'(inflight);

  always_comb begin
    s_ready     = (state == FILL) && mem_ready;
    in_hs       = s_ready && s_valid;
    mem_wr_en   = in_hs;
    mem_wr_addr = in_hs ? waddr : '0;
    mem_wr_data = in_hs ? s_data : '0;
    m_valid     = fifo_valid;
    m_data      = fifo_valid ? fifo_head.data : '0;
    m_last      = fifo_valid && fifo_head.last;
    pop         = fifo_valid && m_ready;
    issue       = (state == DRAIN) && mem_ready && !rd_cnt[ADDR_W] &&
                  (level < 3'd2 + 3'(pop));
    mem_rd_en   = issue;
    mem_rd_addr = issue ? rd_cnt[ADDR_W-1:0] : '0;
    frame_done  = pop && fifo_head.last;
    state_nx    = state;
    case (state)
      FILL:    if (in_hs && wr_cnt == ADDR_W'(DEPTH-1)) state_nx = DRAIN;
      DRAIN:   if (frame_done) state_nx = FILL;
      default: state_nx = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= FILL;
      wr_cnt        <= '0;
      rd_cnt        <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      state         <= state_nx;
      inflight      <= issue;
      inflight_last <= issue && (rd_cnt[ADDR_W-1:0] == ADDR_W'(DEPTH-1));
      if (in_hs) wr_cnt <= wr_cnt + 1'b1;
      if (frame_done)  rd_cnt <= '0;
      else if (issue)  rd_cnt <= rd_cnt + 1'b1;
    end
  end
endmodule
